// File: rtl/semaforo_pkg.sv
// Shared types and constants for the gate sensor path and semaforo_fsm.
// The sensor code layout lives here so both ends agree on bit positions.
package semaforo_pkg;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        DIR_ED = 2'd1,
        DIR_DE = 2'd2,
        FALHA  = 2'd3
    } estado_t;

    localparam logic [2:0] SENSOR_FALHA = 3'b111;

    // Bit positions inside the 3-bit sensor code.
    localparam int SENSOR_BIT_DIR_BEAM = 0;
    localparam int SENSOR_BIT_ESQ      = 1;
    localparam int SENSOR_BIT_DIR      = 2;

    function automatic logic [2:0] monta_sensor(input logic dir, input logic esq, input logic dir_beam);
        logic [2:0] code;
        code                      = '0;
        code[SENSOR_BIT_DIR]      = dir;
        code[SENSOR_BIT_ESQ]      = esq;
        code[SENSOR_BIT_DIR_BEAM] = dir_beam;
        return code;
    endfunction

endpackage

// File: rtl/filtro_debounce.sv
// One beam channel: two-flop synchroniser followed by a counting debouncer.
// The debounced value only flips after DEB_CICLOS consecutive disagreeing samples.
module filtro_debounce #(
    parameter int DEB_CICLOS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int CW = $clog2(DEB_CICLOS + 1);
    localparam logic [CW-1:0] CNT_LIMITE = CW'(DEB_CICLOS - 1);

    logic          sync_1;
    logic          sync_2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Any agreeing sample restarts the count, so short glitches are discarded.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync_2 != deb) begin
            if (cnt == CNT_LIMITE) begin
                deb <= sync_2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/sensor_condicionador.sv
// Conditions the two raw gate beams into the sensor code for semaforo_fsm,
// latching travel direction and flagging completed crossings and ambiguous entries.
module sensor_condicionador
    import semaforo_pkg::*;
#(
    parameter int DEB_CICLOS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       raw_dir,
    input  logic       raw_esq,
    output logic [2:0] sensor,
    output logic       passou,
    output logic       erro
);

    logic    a;
    logic    e;
    estado_t estado;
    estado_t estado_next;
    logic    ambos;
    logic    ambos_next;
    logic    passou_next;
    logic    erro_next;
    logic [2:0] sensor_next;

    filtro_debounce #(.DEB_CICLOS(DEB_CICLOS)) u_filtro_dir (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_dir),
        .deb   (a)
    );

    filtro_debounce #(.DEB_CICLOS(DEB_CICLOS)) u_filtro_esq (
        .clk   (clk),
        .reset (reset),
        .raw   (raw_esq),
        .deb   (e)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado <= OCIOSO;
            ambos  <= 1'b0;
            sensor <= 3'b000;
            passou <= 1'b0;
            erro   <= 1'b0;
        end else begin
            estado <= estado_next;
            ambos  <= ambos_next;
            sensor <= sensor_next;
            passou <= passou_next;
            erro   <= erro_next;
        end
    end

    // Direction is only chosen from OCIOSO; bounces inside a crossing keep it.
    always_comb begin
        estado_next = estado;
        ambos_next  = ambos;
        passou_next = 1'b0;
        unique case (estado)
            OCIOSO: begin
                ambos_next = 1'b0;
                if (a && e)       estado_next = FALHA;
                else if (a && !e) estado_next = DIR_ED;
                else if (!a && e) estado_next = DIR_DE;
            end
            DIR_ED, DIR_DE: begin
                if (!a && !e) begin
                    estado_next = OCIOSO;
                    passou_next = ambos;
                    ambos_next  = 1'b0;
                end else if (a && e) begin
                    ambos_next = 1'b1;
                end
            end
            FALHA: begin
                ambos_next = 1'b0;
                if (!a && !e) estado_next = OCIOSO;
            end
            default: begin
                estado_next = OCIOSO;
                ambos_next  = 1'b0;
            end
        endcase
    end

    // Outputs come from the next state so the dir bit appears with the beam bits.
    always_comb begin
        erro_next = (estado_next == FALHA);
        if (estado_next == FALHA) sensor_next = SENSOR_FALHA;
        else                      sensor_next = monta_sensor(estado_next == DIR_DE, e, a);
    end

endmodule

// File: tb/tb_sensor_condicionador.sv
// Bench for sensor_condicionador: cycle model of the beam conditioning rules,
// per-cycle comparison, and directed scenarios with literal expectations.
module tb_sensor_condicionador;

    localparam int DEB = 4;

    logic       clk;
    logic       reset;
    logic       raw_dir;
    logic       raw_esq;
    logic [2:0] sensor;
    logic       passou;
    logic       erro;

    int errors;
    int checks;
    int dut_pulses;
    bit chk_en;

    sensor_condicionador #(.DEB_CICLOS(DEB)) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_dir (raw_dir),
        .raw_esq (raw_esq),
        .sensor  (sensor),
        .passou  (passou),
        .erro    (erro)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: history of raw samples, run length per channel, crossing bookkeeping.
    logic [1:0] hist_a;
    logic [1:0] hist_e;
    int         run_a;
    int         run_e;
    logic       m_a;
    logic       m_e;
    int         mode;      // 0 idle, 1 crossing, 2 fault
    logic       m_dir;
    logic       m_both;
    logic [2:0] m_sensor;
    logic       m_passou;
    logic       m_erro;

    initial begin
        hist_a = '0; hist_e = '0; run_a = 0; run_e = 0;
        m_a = 0; m_e = 0; mode = 0; m_dir = 0; m_both = 0;
        m_sensor = 3'b000; m_passou = 0; m_erro = 0;
    end

    always @(posedge clk) begin
        if (!reset) begin
            hist_a = '0; hist_e = '0; run_a = 0; run_e = 0;
            m_a = 0; m_e = 0; mode = 0; m_dir = 0; m_both = 0;
            m_sensor = 3'b000; m_passou = 0; m_erro = 0;
        end else begin
            m_passou = 0;
            case (mode)
                0: begin
                    if (m_a && m_e) mode = 2;
                    else if (m_a || m_e) begin
                        mode = 1; m_dir = m_e; m_both = 0;
                    end
                end
                1: begin
                    if (!m_a && !m_e) begin
                        m_passou = m_both; mode = 0; m_both = 0;
                    end else if (m_a && m_e) m_both = 1;
                end
                default: if (!m_a && !m_e) mode = 0;
            endcase
            m_erro   = (mode == 2);
            m_sensor = (mode == 2) ? 3'b111 : {(mode == 1) && m_dir, m_e, m_a};
            // debounced value follows a channel only after DEB straight disagreements
            if (hist_a[1] != m_a) begin
                run_a++;
                if (run_a == DEB) begin m_a = !m_a; run_a = 0; end
            end else run_a = 0;
            if (hist_e[1] != m_e) begin
                run_e++;
                if (run_e == DEB) begin m_e = !m_e; run_e = 0; end
            end else run_e = 0;
            hist_a = {hist_a[0], raw_dir};
            hist_e = {hist_e[0], raw_esq};
        end
    end

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b at %0t", name, act, exp, $time);
        end
    endtask

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            chk("sensor_vs_model", sensor, m_sensor);
            chk("passou_vs_model", {2'b00, passou}, {2'b00, m_passou});
            chk("erro_vs_model", {2'b00, erro}, {2'b00, m_erro});
            chk("passou_and_erro", {2'b00, passou & erro}, 3'b000);
            if (passou === 1'b1) dut_pulses++;
        end
    end

    // driver tasks
    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic d, input logic e, input int n);
        raw_dir = d;
        raw_esq = e;
        hold(n);
    endtask

    int  p0;
    bit  seen;

    initial begin
        errors = 0; checks = 0; dut_pulses = 0; chk_en = 0;
        reset = 1'b0; raw_dir = 1'b1; raw_esq = 1'b0;

        // reset held three edges with the right beam already broken
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_en = 1;
            chk("reset_sensor", sensor, 3'b000);
            chk("reset_passou", {2'b00, passou}, 3'b000);
            chk("reset_erro", {2'b00, erro}, 3'b000);
        end
        reset = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            if (i == 6) chk("latency_edge6", sensor, 3'b000);
            if (i == 7) chk("latency_edge7", sensor, 3'b001);
        end

        // right-to-left crossing continues from the held right beam
        p0 = dut_pulses;
        hold(13);
        chk("rl_right", sensor, 3'b001);
        drive(1, 1, 20); chk("rl_both", sensor, 3'b011);
        drive(0, 1, 20); chk("rl_left", sensor, 3'b010);
        drive(0, 0, 20); chk("rl_clear", sensor, 3'b000);
        chk("rl_pulses", 3'(dut_pulses - p0), 3'd1);

        // left-to-right crossing
        p0 = dut_pulses;
        drive(0, 1, 20); chk("lr_left", sensor, 3'b110);
        drive(1, 1, 20); chk("lr_both", sensor, 3'b111);
        chk("lr_both_no_erro", {2'b00, erro}, 3'b000);
        drive(1, 0, 20); chk("lr_right", sensor, 3'b101);
        drive(0, 0, 20); chk("lr_clear", sensor, 3'b000);
        chk("lr_pulses", 3'(dut_pulses - p0), 3'd1);

        // glitch shorter than the debounce window is dropped
        drive(1, 0, DEB - 1);
        drive(0, 0, 20); chk("glitch_short", sensor, 3'b000);

        // glitch of exactly the window length gets through, then a reverse-out
        p0 = dut_pulses;
        seen = 0;
        drive(1, 0, DEB);
        raw_dir = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sensor === 3'b001) seen = 1;
        end
        chk("glitch_long_seen", {2'b00, seen}, 3'b001);
        chk("glitch_long_end", sensor, 3'b000);

        // simultaneous entry is a fault
        drive(1, 1, 20); chk("simul_sensor", sensor, 3'b111);
        chk("simul_erro", {2'b00, erro}, 3'b001);
        drive(0, 0, 20); chk("simul_clear", sensor, 3'b000);
        chk("simul_erro_clear", {2'b00, erro}, 3'b000);

        // reverse-out: right beam only, then clear
        drive(1, 0, 20); chk("rev_right", sensor, 3'b001);
        drive(0, 0, 20); chk("rev_clear", sensor, 3'b000);
        chk("no_pulse_glitch_simul_rev", 3'(dut_pulses - p0), 3'd0);

        // reset in the middle of a crossing
        p0 = dut_pulses;
        drive(1, 0, 20);
        drive(1, 1, 20); chk("mid_both", sensor, 3'b011);
        reset = 1'b0;
        raw_dir = 0; raw_esq = 0;
        @(negedge clk);
        chk("mid_reset_sensor", sensor, 3'b000);
        chk("mid_reset_passou", {2'b00, passou}, 3'b000);
        hold(2);
        reset = 1'b1;
        hold(20);
        chk("mid_reset_idle", sensor, 3'b000);
        chk("mid_reset_pulses", 3'(dut_pulses - p0), 3'd0);

        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
